// File: rtl/mccontrolunit_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mccontrolunit_fsm_if
// Description : Unified instruction/data memory port between the multi-cycle
//               control unit and the memory. The memory accepts a request on
//               any cycle where mem_req and mem_ready are both high.
//   mem_req   : request, held until mem_ready
//   mem_ready : memory completes the current request this cycle
//   iord      : address select, 0 = PC, 1 = ALU result
//   wmem      : write enable qualifying mem_req
//   Modports  : master (control unit), slave (memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface mccontrolunit_fsm_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic wmem;

  modport master (
    output mem_req,
    output iord,
    output wmem,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  iord,
    input  wmem,
    output mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/mccontrolunit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mccontrolunit_fsm
// Description : Multi-cycle MIPS control unit. Sequences each instruction
//               through FETCH/DECODE/EXEC/MEM/WB over a shared memory port
//               and drives the datapath strobes plus pcwrite/irwrite/iord.
//               Counts retired instructions.
// Parameters  : TIMEOUT - wait cycles before a bus error (1..255)
//               CNT_W   - retired-instruction counter width
// Ports       : clk, rst         - clock, synchronous active-high reset
//               op, func, z      - IR opcode/function, ALU zero flag
//               mem              - memory port (master modport)
//               irwrite, pcwrite, pcsrc, wreg, regrt, jal, m2reg,
//               aluimm, sext, shift, aluc - datapath strobes
//               instr_cnt        - retired instruction count
//               exc, exc_cause   - trap pulse and cause
// Option      : define MCCU_EXC_EN to enable the memory timeout and the
//               illegal-instruction trap; otherwise waits are unbounded,
//               illegal instructions are NOPs and exc/exc_cause read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mccontrolunit_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [5:0]       op,
  input  wire logic [5:0]       func,
  input  wire logic             z,
  mccontrolunit_fsm_if.master   mem,
  output logic                  irwrite,
  output logic                  pcwrite,
  output logic [1:0]            pcsrc,
  output logic                  wreg,
  output logic                  regrt,
  output logic                  jal,
  output logic                  m2reg,
  output logic                  aluimm,
  output logic                  sext,
  output logic                  shift,
  output logic [3:0]            aluc,
  output logic [CNT_W-1:0]      instr_cnt,
  output logic                  exc,
  output logic [1:0]            exc_cause
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
    $error("mccontrolunit_fsm: TIMEOUT must be within 1..255");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;
  logic             mem_req_c, iord_c, wmem_c;

  // Instruction decode (independent of state)
  logic             legal;
  logic [3:0]       aluc_dec;
  logic             shift_dec, aluimm_dec, sext_dec;
  logic             is_j, is_jal, is_jr, is_beq, is_bne, is_lw, is_sw;

  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign is_jr  = (op == OP_RTYPE) && (func == FN_JR);
  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);

`ifdef MCCU_EXC_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic              timeout;

  // True while the current waiting cycle is the TIMEOUT-th one.
  assign timeout = (wait_q == WAIT_W'(TIMEOUT - 1));
`endif

  // ALU control keeps the single-cycle encoding; don't-care bits are 0.
  always_comb begin
    legal      = 1'b0;
    aluc_dec   = 4'b0000;
    shift_dec  = 1'b0;
    aluimm_dec = 1'b0;
    sext_dec   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin legal = 1'b1; aluc_dec = 4'b0000; end
          FN_SUB: begin legal = 1'b1; aluc_dec = 4'b0100; end
          FN_AND: begin legal = 1'b1; aluc_dec = 4'b0001; end
          FN_OR:  begin legal = 1'b1; aluc_dec = 4'b0101; end
          FN_XOR: begin legal = 1'b1; aluc_dec = 4'b0010; end
          FN_SLL: begin legal = 1'b1; aluc_dec = 4'b0011; shift_dec = 1'b1; end
          FN_SRL: begin legal = 1'b1; aluc_dec = 4'b0111; shift_dec = 1'b1; end
          FN_SRA: begin legal = 1'b1; aluc_dec = 4'b1111; shift_dec = 1'b1; end
          FN_JR:  legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin legal = 1'b1; aluimm_dec = 1'b1; sext_dec = 1'b1; aluc_dec = 4'b0000; end
      OP_ANDI: begin legal = 1'b1; aluimm_dec = 1'b1; aluc_dec = 4'b0001; end
      OP_ORI:  begin legal = 1'b1; aluimm_dec = 1'b1; aluc_dec = 4'b0101; end
      OP_XORI: begin legal = 1'b1; aluimm_dec = 1'b1; aluc_dec = 4'b0010; end
      OP_LUI:  begin legal = 1'b1; aluimm_dec = 1'b1; aluc_dec = 4'b0110; end
      OP_LW, OP_SW: begin
        legal = 1'b1; aluimm_dec = 1'b1; sext_dec = 1'b1; aluc_dec = 4'b0000;
      end
      OP_BEQ, OP_BNE: begin legal = 1'b1; sext_dec = 1'b1; aluc_dec = 4'b0010; end
      OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Sequencer: next state and all outputs decode from state_q plus inputs.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req_c = 1'b0;
    iord_c    = 1'b0;
    wmem_c    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pcsrc     = 2'b00;
    wreg      = 1'b0;
    regrt     = 1'b0;
    jal       = 1'b0;
    m2reg     = 1'b0;
    aluimm    = 1'b0;
    sext      = 1'b0;
    shift     = 1'b0;
    aluc      = 4'b0000;
    exc       = 1'b0;
    exc_cause = 2'b00;
`ifdef MCCU_EXC_EN
    cause_d   = cause_q;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
`ifdef MCCU_EXC_EN
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
`endif
      end
      S_DECODE: begin
        if (!legal) begin
`ifdef MCCU_EXC_EN
          state_d = S_TRAP;
          cause_d = 2'b01;
`else
          state_d = S_FETCH;
`endif
        end else if (is_j || is_jal) begin
          pcwrite = 1'b1;
          pcsrc   = 2'b11;
          wreg    = is_jal;
          jal     = is_jal;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (is_jr) begin
          pcwrite = 1'b1;
          pcsrc   = 2'b10;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluc   = aluc_dec;
        shift  = shift_dec;
        aluimm = aluimm_dec;
        sext   = sext_dec;
        if (is_beq || is_bne) begin
          if ((is_beq && z) || (is_bne && !z)) begin
            pcwrite = 1'b1;
            pcsrc   = 2'b01;
          end
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        wmem_c    = is_sw;
        if (mem.mem_ready) begin
          if (is_sw) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
`ifdef MCCU_EXC_EN
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
`endif
      end
      S_WB: begin
        wreg    = 1'b1;
        regrt   = (op != OP_RTYPE);
        m2reg   = is_lw;
        aluc    = aluc_dec;
        shift   = shift_dec;
        aluimm  = aluimm_dec;
        sext    = sext_dec;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: begin
        // Datapath muxes the exception vector in on pcsrc=11 during TRAP.
`ifdef MCCU_EXC_EN
        exc       = 1'b1;
        exc_cause = cause_q;
        pcwrite   = 1'b1;
        pcsrc     = 2'b11;
`endif
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset squashes every strobe so a pending request or write is dropped.
    if (rst) begin
      state_d   = S_FETCH;
      retire    = 1'b0;
      mem_req_c = 1'b0;
      iord_c    = 1'b0;
      wmem_c    = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      pcsrc     = 2'b00;
      wreg      = 1'b0;
      regrt     = 1'b0;
      jal       = 1'b0;
      m2reg     = 1'b0;
      aluimm    = 1'b0;
      sext      = 1'b0;
      shift     = 1'b0;
      aluc      = 4'b0000;
      exc       = 1'b0;
      exc_cause = 2'b00;
    end

    instr_cnt_d = retire ? (instr_cnt_q + CNT_W'(1)) : instr_cnt_q;

`ifdef MCCU_EXC_EN
    // Counter restarts on every state change, so entry to FETCH or MEM
    // always begins a fresh wait budget.
    wait_d = wait_q;
    if (rst || (state_d != state_q)) begin
      wait_d = '0;
    end else if (mem_req_c && !mem.mem_ready) begin
      wait_d = wait_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

`ifdef MCCU_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end
`endif

  assign mem.mem_req = mem_req_c;
  assign mem.iord    = iord_c;
  assign mem.wmem    = wmem_c;
  assign instr_cnt   = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mccontrolunit_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mccontrolunit_fsm
// Description : Self-checking bench for mccontrolunit_fsm. A per-instruction
//               reference model expands each instruction into its expected
//               per-cycle strobe pattern and retirement count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mccontrolunit_fsm;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;

  typedef struct packed {
    logic       mem_req, iord, wmem, irwrite, pcwrite;
    logic [1:0] pcsrc;
    logic       wreg, regrt, jal, m2reg, aluimm, sext, shift;
    logic [3:0] aluc;
    logic       exc;
    logic [1:0] exc_cause;
  } strobes_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       op, func;
  logic             z;
  logic             irwrite, pcwrite, wreg, regrt, jal, m2reg, aluimm, sext, shift, exc;
  logic [1:0]       pcsrc, exc_cause;
  logic [3:0]       aluc;
  logic [CNT_W-1:0] instr_cnt;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  logic [5:0] ops   [14] = '{OP_R, OP_R, OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                             OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL};
  logic [5:0] funcs [9]  = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SRL, F_SRA, F_JR};

  mccontrolunit_fsm_if bus ();

  mccontrolunit_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .func      (func),
    .z         (z),
    .mem       (bus.master),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .pcsrc     (pcsrc),
    .wreg      (wreg),
    .regrt     (regrt),
    .jal       (jal),
    .m2reg     (m2reg),
    .aluimm    (aluimm),
    .sext      (sext),
    .shift     (shift),
    .aluc      (aluc),
    .instr_cnt (instr_cnt),
    .exc       (exc),
    .exc_cause (exc_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic strobes_t sample();
    strobes_t s;
    s.mem_req = bus.mem_req; s.iord = bus.iord; s.wmem = bus.wmem;
    s.irwrite = irwrite; s.pcwrite = pcwrite; s.pcsrc = pcsrc;
    s.wreg = wreg; s.regrt = regrt; s.jal = jal; s.m2reg = m2reg;
    s.aluimm = aluimm; s.sext = sext; s.shift = shift; s.aluc = aluc;
    s.exc = exc; s.exc_cause = exc_cause;
    return s;
  endfunction

  function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_R)
      return (f == F_ADD || f == F_SUB || f == F_AND || f == F_OR || f == F_XOR ||
              f == F_SLL || f == F_SRL || f == F_SRA || f == F_JR);
    return (o == OP_ADDI || o == OP_ANDI || o == OP_ORI || o == OP_XORI || o == OP_LUI ||
            o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_BNE || o == OP_J || o == OP_JAL);
  endfunction

  // {aluimm, sext, shift, aluc[3:0]} of the single-cycle decoder
  function automatic logic [6:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_R: case (f)
        F_ADD: return 7'b000_0000;
        F_SUB: return 7'b000_0100;
        F_AND: return 7'b000_0001;
        F_OR:  return 7'b000_0101;
        F_XOR: return 7'b000_0010;
        F_SLL: return 7'b001_0011;
        F_SRL: return 7'b001_0111;
        F_SRA: return 7'b001_1111;
        default: return 7'b000_0000;
      endcase
      OP_ADDI:       return 7'b110_0000;
      OP_ANDI:       return 7'b100_0001;
      OP_ORI:        return 7'b100_0101;
      OP_XORI:       return 7'b100_0010;
      OP_LUI:        return 7'b100_0110;
      OP_LW, OP_SW:  return 7'b110_0000;
      OP_BEQ, OP_BNE: return 7'b010_0010;
      default:       return 7'b000_0000;
    endcase
  endfunction

  function automatic strobes_t with_alu(input logic [6:0] a);
    strobes_t e = '0;
    e.aluimm = a[6]; e.sext = a[5]; e.shift = a[4]; e.aluc = a[3:0];
    return e;
  endfunction

  // One clock: drive mem_ready, compare strobes mid-cycle, advance.
  task automatic cyc(input logic rdy, input strobes_t e, input string tag);
    bus.mem_ready = rdy;
    @(negedge clk);
    check(tag, 64'(sample()), 64'(e));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic wait_phase(input int n, input strobes_t ew, input string tag, output bit trapped);
    strobes_t et;
    trapped = 1'b0;
`ifdef MCCU_EXC_EN
    if (n >= TIMEOUT) begin
      repeat (TIMEOUT) cyc(1'b0, ew, tag);
      et = '0; et.exc = 1'b1; et.pcwrite = 1'b1; et.pcsrc = 2'b11; et.exc_cause = 2'b10;
      cyc(rnd_bit(), et, "trap_timeout");
      trapped = 1'b1;
      return;
    end
`endif
    repeat (n) cyc(1'b0, ew, tag);
  endtask

  // Expected behaviour of one instruction with wf fetch and wm memory waits.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zz,
                           input int wf, input int wm);
    strobes_t   e;
    bit         tr;
    logic [6:0] a;
    a = alu_of(o, f);
    op = o; func = f; z = zz;
    e = '0; e.mem_req = 1'b1;
    wait_phase(wf, e, "fetch_wait", tr);
    if (!tr) begin
      e.irwrite = 1'b1; e.pcwrite = 1'b1;
      cyc(1'b1, e, "fetch");
      e = '0;
      if (!is_legal(o, f)) begin
        cyc(rnd_bit(), e, "decode_illegal");
`ifdef MCCU_EXC_EN
        e.exc = 1'b1; e.pcwrite = 1'b1; e.pcsrc = 2'b11; e.exc_cause = 2'b01;
        cyc(rnd_bit(), e, "trap_illegal");
`endif
      end else if (o == OP_J || o == OP_JAL) begin
        e.pcwrite = 1'b1; e.pcsrc = 2'b11; e.wreg = (o == OP_JAL); e.jal = (o == OP_JAL);
        cyc(rnd_bit(), e, "decode_jump");
        exp_cnt++;
      end else if (o == OP_R && f == F_JR) begin
        e.pcwrite = 1'b1; e.pcsrc = 2'b10;
        cyc(rnd_bit(), e, "decode_jr");
        exp_cnt++;
      end else begin
        cyc(rnd_bit(), e, "decode");
        e = with_alu(a);
        if (o == OP_BEQ || o == OP_BNE) begin
          if ((o == OP_BEQ && zz) || (o == OP_BNE && !zz)) begin
            e.pcwrite = 1'b1; e.pcsrc = 2'b01;
          end
          cyc(rnd_bit(), e, "exec_branch");
          exp_cnt++;
        end else begin
          cyc(rnd_bit(), e, "exec");
          tr = 1'b0;
          if (o == OP_LW || o == OP_SW) begin
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.wmem = (o == OP_SW);
            wait_phase(wm, e, "mem_wait", tr);
            if (!tr) begin
              cyc(1'b1, e, "mem");
              if (o == OP_SW) exp_cnt++;
            end
          end
          if (!tr && o != OP_SW) begin
            e = with_alu(a);
            e.wreg = 1'b1; e.regrt = (o != OP_R); e.m2reg = (o == OP_LW);
            cyc(rnd_bit(), e, "wb");
            exp_cnt++;
          end
        end
      end
    end
    check("instr_cnt", 64'(instr_cnt), 64'(exp_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reset_strobes", 64'(sample()), 64'(0));
      @(posedge clk);
      #1;
    end
    check("reset_instr_cnt", 64'(instr_cnt), 64'(0));
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    strobes_t   e;
    logic [5:0] o, f;
    int         wf, wm;
    rst = 1'b1; op = '0; func = '0; z = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Zero-wait sequence
    run_instr(OP_ADDI, 6'h00, 1'b0, 0, 0);
    run_instr(OP_LW,   6'h00, 1'b0, 0, 0);
    run_instr(OP_SW,   6'h00, 1'b0, 0, 0);
    run_instr(OP_BEQ,  6'h00, 1'b1, 0, 0);
    run_instr(OP_J,    6'h00, 1'b0, 0, 0);
    check("cnt_after_five", 64'(instr_cnt), 64'(5));

    // Stalls, branches, jumps, illegal encodings, timeouts
    run_instr(OP_LW,  6'h00, 1'b0, 0, 3);
    run_instr(OP_BNE, 6'h00, 1'b1, 0, 0);
    run_instr(OP_BNE, 6'h00, 1'b0, 2, 0);
    run_instr(OP_R,   F_JR,  1'b0, 0, 0);
    run_instr(OP_JAL, 6'h00, 1'b0, 0, 0);
    run_instr(OP_R,   F_SUB, 1'b0, 1, 0);
    run_instr(OP_R,   F_SRA, 1'b0, 0, 0);
    run_instr(6'h3f,  6'h00, 1'b0, 0, 0);
    run_instr(OP_R,   6'h3f, 1'b0, 0, 0);
    run_instr(OP_ADDI, 6'h00, 1'b0, TIMEOUT, 0);
    run_instr(OP_LW,   6'h00, 1'b0, 0, TIMEOUT);
    run_instr(OP_SW,   6'h00, 1'b0, TIMEOUT - 1, TIMEOUT - 1);

    // Reset in the middle of a store: the write must never be issued
    op = OP_SW; func = 6'h00;
    e = '0; e.mem_req = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    cyc(1'b1, e, "rst_fetch");
    e = '0;
    cyc(1'b0, e, "rst_decode");
    e = with_alu(alu_of(OP_SW, 6'h00));
    cyc(1'b0, e, "rst_exec");
    rst = 1'b1;
    e = '0;
    cyc(1'b1, e, "rst_mem_squashed");
    rst = 1'b0;
    exp_cnt = '0;
    check("rst_mid_instr_cnt", 64'(instr_cnt), 64'(exp_cnt));

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 8) begin
        o = 6'($urandom);
        f = 6'($urandom);
      end else begin
        o = ops[$urandom_range(0, 13)];
        f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 8)];
      end
      wf = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      wm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      run_instr(o, f, rnd_bit(), wf, wm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mccontrolunit_fsm.md
Name: mccontrolunit_fsm

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory with a req/ready handshake.
- Drives the same datapath strobe set plus multi-cycle enables: pcwrite, irwrite, iord.
- Parametrised memory timeout; counts retired instructions. Sits between the IR/flags of the datapath and the unified memory port.

Parameters:
- TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a bus error (EXC_EN only); legal range 1..255.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  6  IR[31:26], stable from DECODE onward
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- iord  out  1  0 = PC address, 1 = ALU address
- irwrite  out  1  load IR
- pcwrite  out  1  load PC from the pcsrc mux
- pcsrc  out  2  00 PC+4, 01 branch, 10 jr, 11 jump
- wmem  out  1  write-enable qualifying mem_req
- wreg  out  1  register-file write
- regrt  out  1  destination is rt (1) or rd (0)
- jal  out  1  write PC+4 to r31
- m2reg  out  1  write-back source is memory
- aluimm  out  1  ALU B = immediate
- sext  out  1  sign-extend the immediate
- shift  out  1  ALU A = shamt
- aluc  out  4  ALU op; encoding unchanged from the single-cycle unit, with don't-care bits driven 0
- instr_cnt  out  CNT_W  retired instructions
- exc  out  1  trap pulse (EXC_EN only, else tied 0)
- exc_cause  out  2  01 illegal op, 10 bus timeout (EXC_EN only, else 0)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset:
  - State goes to FETCH and instr_cnt to 0.
  - While rst is high, every strobe output is forced to 0, so a mem_ready arriving in the reset cycle is ignored.
  - Reset applied mid-instruction discards the instruction with no writes.
- Output timing: all outputs decode combinationally from the state register plus op/func/z. Strobes are 0 in any state not listed below.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ready: irwrite=1, pcwrite=1, pcsrc=00, go to DECODE. Otherwise stay.
- DECODE:
  - j: pcwrite=1, pcsrc=11, go to FETCH.
  - jal: as j, plus wreg=1, jal=1.
  - R-type jr (func 001000): pcwrite=1, pcsrc=10, go to FETCH.
  - Other legal ops go to EXEC.
  - Legal ops: R-type add/sub/and/or/xor/sll/srl/sra/jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal.
  - sub func is 100010 (corrected; no overlap with srl 000010).
  - Illegal op or func: go to TRAP (EXC_EN) or FETCH (treated as NOP, not counted).
- EXEC:
  - aluc/shift/aluimm/sext follow the single-cycle mapping.
  - beq/bne: aluc=x010; pcwrite=1, pcsrc=01 if (beq and z) or (bne and !z); go to FETCH.
  - lw/sw: aluc=000, aluimm=1, sext=1, go to MEM.
  - All others go to WB.
- MEM:
  - mem_req=1, iord=1, wmem=(op==sw).
  - On mem_ready: sw goes to FETCH, lw goes to WB.
- WB:
  - wreg=1, regrt=(op!=0), m2reg=(op==lw).
  - ALU control held from EXEC values.
  - Go to FETCH.
- Retirement: instr_cnt increments by 1 on every transition into FETCH from DECODE (jumps), EXEC (branches), MEM (sw) or WB. Wraps modulo 2^CNT_W.
- Nominal CPI with zero wait states (mem_ready=1 on first request cycle): jump 2, branch 3, sw 4, ALU/lui 4, lw 5. Each wait cycle adds 1.
- Stalls: mem_ready low holds all outputs constant.

Optional Feature:
- Macro: MCCU_EXC_EN.
- When defined:
  - A wait counter (clog2(TIMEOUT+1) bits) clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - Reaching TIMEOUT goes to TRAP with cause 10.
  - An illegal op in DECODE goes to TRAP with cause 01.
  - TRAP lasts 1 cycle: exc=1, pcwrite=1, pcsrc=11 (datapath muxes the exception vector), no wreg/wmem, not counted, then FETCH.
  - Timeout and mem_ready arriving in the same cycle: mem_ready wins.
- When undefined: no counter, unbounded wait, illegal ops act as NOP, exc and exc_cause tied 0.

Test Plan:
- rst=1 for 2 cycles with mem_ready=1 -> all strobes 0, instr_cnt=0; first cycle after reset mem_req=1, iord=0.
- Zero-wait sequence addi, lw, sw, beq(z=1), j -> cycle counts 4, 5, 4, 3, 2; instr_cnt=5; beq asserts pcwrite with pcsrc=01 in EXEC.
- lw with mem_ready delayed 3 cycles in MEM -> outputs frozen (mem_req=1, iord=1) for 3 cycles; WB asserts wreg=1, m2reg=1, regrt=1.
- bne with z=1 -> pcwrite=0 in EXEC; jr (op 0, func 001000) -> pcwrite=1, pcsrc=10 in DECODE; jal -> wreg=1, jal=1.
- MCCU_EXC_EN, TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 wait cycles: TRAP with exc=1, exc_cause=10, pcsrc=11; then FETCH; instr_cnt unchanged.
- op=111111 -> with macro: TRAP, exc_cause=01. Without macro: back to FETCH after DECODE, instr_cnt unchanged.
